// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-outstanding memory controller among
// NUM_REQ requesters. Round-robin grant, one transaction in flight:
// accept -> issue -> wait -> respond. All handshake outputs are registered.
module memory_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_addr_valid,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]     req_data_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_data,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic                   mc_addr_valid,
  output logic [31:0]            mc_addr,
  output logic                   mc_data_valid,
  output logic [31:0]            mc_data,
  input  logic                   mc_ready,
  input  logic                   mc_send_valid,
  input  logic [31:0]            mc_send_data,
  output logic                   mc_send_ready,
  output logic [IDX_W-1:0]       gnt_id,
  output logic                   busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] last;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  logic             sel_valid;
  logic             sel_ready;
  logic             sel_write;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_data;
  logic             sel_resp_valid;
  logic             sel_resp_ready;

  // Next grant: first requesting port scanning last+1, last+2, ... modulo NUM_REQ.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pick_valid && req_addr_valid[i] && (i == (int'(last) + k) % NUM_REQ)) begin
          pick_valid = 1'b1;
          pick_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Route the granted requester's request and response handshake signals.
  always_comb begin
    sel_valid      = 1'b0;
    sel_ready      = 1'b0;
    sel_write      = 1'b0;
    sel_addr       = '0;
    sel_data       = '0;
    sel_resp_valid = 1'b0;
    sel_resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == gnt) begin
        sel_valid      = req_addr_valid[i];
        sel_ready      = req_ready[i];
        sel_write      = req_data_valid[i];
        sel_addr       = req_addr[32*i +: 32];
        sel_data       = req_data[32*i +: 32];
        sel_resp_valid = resp_valid[i];
        sel_resp_ready = resp_ready[i];
      end
    end
  end

  // Transaction FSM: grant, accept request, issue to controller, wait for data, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking (<=) so every register update in this block sees the pre-edge values of the others.
    if (!rst_n) begin
      state         <= S_IDLE;
      last          <= IDX_W'(NUM_REQ - 1);
      gnt           <= '0;
      req_ready     <= '0;
      resp_valid    <= '0;
      resp_data     <= '0;
      mc_addr_valid <= 1'b0;
      mc_addr       <= '0;
      mc_data_valid <= 1'b0;
      mc_data       <= '0;
      mc_send_ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            gnt       <= pick_idx;
            req_ready <= NUM_REQ'(1) << pick_idx;
            state     <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          req_ready <= '0;
          if (sel_valid && sel_ready) begin
            mc_addr       <= sel_addr;
            mc_data       <= sel_data;
            mc_addr_valid <= 1'b1;
            mc_data_valid <= sel_write;
            state         <= S_ISSUE;
          end else begin
            // Requester withdrew before the transfer: abandon, keep fairness pointer.
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (mc_addr_valid && mc_ready) begin
            mc_addr_valid <= 1'b0;
            mc_data_valid <= 1'b0;
            mc_addr       <= '0;
            mc_data       <= '0;
            mc_send_ready <= 1'b1;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mc_send_valid && mc_send_ready) begin
            resp_data     <= mc_send_data;
            mc_send_ready <= 1'b0;
            resp_valid    <= NUM_REQ'(1) << gnt;
            state         <= S_RESP;
          end
        end
        S_RESP: begin
          if (sel_resp_valid && sel_resp_ready) begin
            resp_valid <= '0;
            resp_data  <= '0;
            last       <= gnt;
            gnt        <= '0;
            state      <= S_IDLE;
          end
        end
        default: begin
          req_ready     <= '0;
          resp_valid    <= '0;
          mc_addr_valid <= 1'b0;
          mc_data_valid <= 1'b0;
          mc_send_ready <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_id = gnt;
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: requester and controller models driven on the
// falling edge, per-port scoreboard of expected responses, scenario tasks.
module tb_memory_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req_addr_valid, req_data_valid, req_ready;
  logic [NUM_REQ-1:0]    resp_valid, resp_ready;
  logic [32*NUM_REQ-1:0] req_addr, req_data;
  logic [31:0]           resp_data, mc_addr, mc_data, mc_send_data;
  logic                  mc_addr_valid, mc_data_valid, mc_ready;
  logic                  mc_send_valid, mc_send_ready, busy;
  logic [IDX_W-1:0]      gnt_id;

  memory_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr_valid(req_addr_valid), .req_addr(req_addr),
    .req_data_valid(req_data_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready),
    .mc_addr_valid(mc_addr_valid), .mc_addr(mc_addr),
    .mc_data_valid(mc_data_valid), .mc_data(mc_data), .mc_ready(mc_ready),
    .mc_send_valid(mc_send_valid), .mc_send_data(mc_send_data),
    .mc_send_ready(mc_send_ready), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t pend_q[NUM_REQ][$];   // requests still to be presented
  txn_t exp_q[NUM_REQ][$];    // expected responses per port
  int   grant_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  bit          acc_pend[NUM_REQ];
  int          cur_port = -1;
  int          mc_stall = 0;
  int          mc_delay = 0;
  bit          mc_have = 1'b0;
  bit          send_done = 1'b0;
  bit          resp_due = 1'b0;
  int          mc_wait_left = 0;
  logic [31:0] mc_rdata = '0;
  int          resp_stall[NUM_REQ];
  int          mc_xfers = 0, resp_xfers = 0;
  int          mc_valid_cycles = 0, resp_valid_cycles = 0;
  int          last_resp_port = -1;

  task automatic enqueue(input int p, input logic [31:0] a, input bit w,
                         input logic [31:0] wd, input logic [31:0] rd);
    txn_t t;
    t.addr = a; t.wr = w; t.wdata = wd; t.rdata = rd;
    pend_q[p].push_back(t);
    exp_q[p].push_back(t);
  endtask

  task automatic bfm_clear();
    for (int p = 0; p < NUM_REQ; p++) begin
      pend_q[p].delete();
      exp_q[p].delete();
      acc_pend[p]   = 1'b0;
      resp_stall[p] = 0;
    end
    req_addr_valid = '0; req_data_valid = '0; req_addr = '0; req_data = '0;
    resp_ready = '0; mc_ready = 1'b0; mc_send_valid = 1'b0; mc_send_data = '0;
    cur_port = -1; mc_have = 1'b0; send_done = 1'b0; resp_due = 1'b0;
    mc_stall = 0; mc_delay = 0; mc_wait_left = 0;
  endtask

  // One falling-edge step of the requester, controller and response models.
  task automatic bfm_step();
    logic [NUM_REQ-1:0] g1;
    g1 = NUM_REQ'(1) << gnt_id;
    if (resp_due) begin
      resp_due = 1'b0;
      n_checks++;
      if (resp_valid !== (NUM_REQ'(1) << cur_port)) begin
        n_fail++;
        $display("FAIL resp_latency: resp_valid=%b required one-hot port %0d", resp_valid, cur_port);
      end
    end
    n_checks++;
    if ((req_ready !== '0 && req_ready !== g1) || (resp_valid !== '0 && resp_valid !== g1)) begin
      n_fail++;
      $display("FAIL onehot_gnt: req_ready=%b resp_valid=%b gnt_id=%0d", req_ready, resp_valid, gnt_id);
    end
    // requesters
    for (int p = 0; p < NUM_REQ; p++) begin
      if (acc_pend[p]) begin
        void'(pend_q[p].pop_front());
        acc_pend[p] = 1'b0;
      end
      if (pend_q[p].size() > 0) begin
        req_addr_valid[p]     = 1'b1;
        req_data_valid[p]     = pend_q[p][0].wr;
        req_addr[32*p +: 32]  = pend_q[p][0].addr;
        req_data[32*p +: 32]  = pend_q[p][0].wdata;
      end else begin
        req_addr_valid[p] = 1'b0;
        req_data_valid[p] = 1'b0;
      end
      if (req_addr_valid[p] && req_ready[p]) begin
        acc_pend[p] = 1'b1;
        cur_port    = p;
        grant_log.push_back(p);
        n_checks++;
        if (gnt_id !== IDX_W'(p)) begin
          n_fail++;
          $display("FAIL accept_gnt_id: gnt_id=%0d required %0d", gnt_id, p);
        end
      end
    end
    // controller send side
    if (send_done) begin
      mc_send_valid = 1'b0;
      send_done     = 1'b0;
    end
    if (mc_have) begin
      if (mc_wait_left > 0) mc_wait_left--;
      else begin
        mc_send_valid = 1'b1;
        mc_send_data  = mc_rdata;
        if (mc_send_ready) begin
          send_done = 1'b1;
          mc_have   = 1'b0;
          resp_due  = 1'b1;
        end
      end
    end
    // controller receive side
    if (mc_addr_valid) begin
      mc_valid_cycles++;
      n_checks++;
      if (cur_port < 0 || exp_q[cur_port].size() == 0) begin
        n_fail++;
        $display("FAIL mc_unexpected: mc_addr=%h with no outstanding request", mc_addr);
      end else if (mc_addr !== exp_q[cur_port][0].addr || mc_data_valid !== exp_q[cur_port][0].wr ||
                   (exp_q[cur_port][0].wr && mc_data !== exp_q[cur_port][0].wdata)) begin
        n_fail++;
        $display("FAIL mc_request: addr=%h wr=%b data=%h required addr=%h wr=%b data=%h",
                 mc_addr, mc_data_valid, mc_data, exp_q[cur_port][0].addr,
                 exp_q[cur_port][0].wr, exp_q[cur_port][0].wdata);
      end
      if (mc_stall > 0) begin
        mc_ready = 1'b0;
        mc_stall--;
      end else begin
        mc_ready = 1'b1;
        mc_xfers++;
        mc_have      = 1'b1;
        mc_wait_left = mc_delay;
        if (cur_port >= 0 && exp_q[cur_port].size() > 0) mc_rdata = exp_q[cur_port][0].rdata;
      end
    end else begin
      mc_ready = 1'b0;
    end
    // response consumers
    if (resp_valid !== '0) resp_valid_cycles++;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (resp_valid[p]) begin
        n_checks++;
        if (exp_q[p].size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: port %0d data=%h with nothing expected", p, resp_data);
        end else if (resp_data !== exp_q[p][0].rdata) begin
          n_fail++;
          $display("FAIL resp_data: port %0d data=%h required %h", p, resp_data, exp_q[p][0].rdata);
        end
        if (resp_stall[p] > 0) begin
          resp_ready[p] = 1'b0;
          resp_stall[p]--;
        end else begin
          resp_ready[p] = 1'b1;
          if (exp_q[p].size() > 0) void'(exp_q[p].pop_front());
          resp_xfers++;
          last_resp_port = p;
        end
      end else begin
        resp_ready[p] = 1'b1;
      end
    end
  endtask

  initial begin
    bfm_clear();
    forever begin
      @(negedge clk);
      if (rst_n) bfm_step();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit drained();
    drained = !busy;
    for (int p = 0; p < NUM_REQ; p++)
      if (pend_q[p].size() != 0 || exp_q[p].size() != 0) drained = 1'b0;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #2;
      done = drained();
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: not drained after %0d cycles, busy=%b", name, budget, busy);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    bfm_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({req_ready, resp_valid, resp_data, mc_addr_valid, mc_addr, mc_data_valid,
         mc_data, mc_send_ready, gnt_id, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req_ready=%b resp_valid=%b mc_addr_valid=%b busy=%b required all zero",
               req_ready, resp_valid, mc_addr_valid, busy);
    end
    apply_reset();
  endtask

  task automatic test_round_robin();
    apply_reset();
    grant_log.delete();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NUM_REQ; p++)
        enqueue(p, 32'h1000 + 32'(16*p + 4*r), 1'b0, '0, 32'hA000_0000 + 32'(16*p + r));
    wait_drain("round_robin", 400);
    n_checks++;
    if (grant_log.size() != 8) begin
      n_fail++;
      $display("FAIL rr_count: %0d grants required 8", grant_log.size());
    end
    for (int i = 0; i < grant_log.size() && i < 8; i++) begin
      n_checks++;
      if (grant_log[i] != i % NUM_REQ) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: granted %0d required %0d", i, grant_log[i], i % NUM_REQ);
      end
    end
  endtask

  task automatic test_single_read();
    enqueue(1, 32'h0000_0100, 1'b0, '0, 32'hDEAD_BEEF);
    @(posedge clk); #2;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL t1_req_ready: %b required 0010", req_ready);
    end
    @(posedge clk); #2;
    n_checks++;
    if (mc_addr_valid !== 1'b1 || mc_addr !== 32'h100 || mc_data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_mc_issue: valid=%b addr=%h wr=%b required 1 00000100 0",
               mc_addr_valid, mc_addr, mc_data_valid);
    end
    wait_drain("single_read", 50);
    n_checks++;
    if (last_resp_port != 1) begin
      n_fail++;
      $display("FAIL t1_resp_port: %0d required 1", last_resp_port);
    end
  endtask

  task automatic test_write();
    bit seen = 1'b0;
    enqueue(2, 32'h0000_0040, 1'b1, 32'h1234_5678, 32'hCAFE_F00D);
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #2;
      seen = mc_addr_valid;
    end
    n_checks++;
    if (!seen || mc_data_valid !== 1'b1 || mc_data !== 32'h1234_5678 || gnt_id !== 2'd2) begin
      n_fail++;
      $display("FAIL t2_write_issue: seen=%b wr=%b data=%h gnt=%0d required 1 1 12345678 2",
               seen, mc_data_valid, mc_data, gnt_id);
    end
    wait_drain("write", 50);
    n_checks++;
    if (last_resp_port != 2) begin
      n_fail++;
      $display("FAIL t2_resp_port: %0d required 2", last_resp_port);
    end
  endtask

  task automatic test_backpressure();
    int mc0 = mc_xfers, rs0 = resp_xfers, mv0 = mc_valid_cycles, rv0 = resp_valid_cycles;
    mc_stall      = 5;
    resp_stall[0] = 3;
    enqueue(0, 32'h0000_0200, 1'b0, '0, 32'h0BAD_F00D);
    wait_drain("backpressure", 80);
    n_checks++;
    if (mc_xfers - mc0 != 1 || resp_xfers - rs0 != 1) begin
      n_fail++;
      $display("FAIL t4_transfers: mc=%0d resp=%0d required 1 1", mc_xfers - mc0, resp_xfers - rs0);
    end
    n_checks++;
    if (mc_valid_cycles - mv0 != 6 || resp_valid_cycles - rv0 != 4) begin
      n_fail++;
      $display("FAIL t4_hold_cycles: mc_valid=%0d resp_valid=%0d required 6 4",
               mc_valid_cycles - mv0, resp_valid_cycles - rv0);
    end
  endtask

  task automatic test_async_reset();
    bit in_wait = 1'b0;
    mc_delay = 10;
    enqueue(2, 32'h0000_0300, 1'b0, '0, 32'h1111_2222);
    for (int c = 0; c < 30 && !in_wait; c++) begin
      @(posedge clk); #2;
      in_wait = mc_send_ready;
    end
    n_checks++;
    if (!in_wait) begin
      n_fail++;
      $display("FAIL t5_reach_wait: mc_send_ready=%b required 1", mc_send_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_data, mc_addr_valid, mc_addr, mc_data_valid,
         mc_data, mc_send_ready, gnt_id, busy} !== '0) begin
      n_fail++;
      $display("FAIL t5_async_clear: mc_send_ready=%b busy=%b gnt_id=%0d required all zero",
               mc_send_ready, busy, gnt_id);
    end
    bfm_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    grant_log.delete();
    enqueue(3, 32'h0000_0330, 1'b0, '0, 32'h3333_0000);
    enqueue(2, 32'h0000_0320, 1'b0, '0, 32'h2222_0000);
    enqueue(0, 32'h0000_0300, 1'b0, '0, 32'h0000_3000);
    wait_drain("async_reset", 100);
    n_checks++;
    if (grant_log.size() != 3 || grant_log[0] != 0 || grant_log[1] != 2 || grant_log[2] != 3) begin
      n_fail++;
      $display("FAIL t5_order_after_reset: %p required '{0,2,3}", grant_log);
    end
  endtask

  task automatic test_wrap();
    bit got = 1'b0;
    bit done = 1'b0;
    grant_log.delete();
    enqueue(3, 32'h0000_03FC, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #2;
      got = req_ready[3];
    end
    n_checks++;
    if (!got || gnt_id !== 2'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_grant: req_ready=%b gnt_id=%0d busy=%b required 1000 3 1", req_ready, gnt_id, busy);
    end
    for (int c = 0; c < 50 && !done; c++) begin
      @(posedge clk); #2;
      n_checks++;
      if (exp_q[3].size() == 0) begin
        done = 1'b1;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL t6_idle_after_resp: busy=%b required 0", busy);
        end
      end else if (busy !== 1'b1 || gnt_id !== 2'd3) begin
        n_fail++;
        $display("FAIL t6_busy_hold: busy=%b gnt_id=%0d required 1 3", busy, gnt_id);
      end
    end
    n_checks++;
    if (!done || grant_log.size() != 1 || grant_log[0] != 3) begin
      n_fail++;
      $display("FAIL t6_wrap: done=%b grants=%p required '{3}", done, grant_log);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_write();
    test_backpressure();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
